// File: rtl/dec_onehot_pipe.sv
// Registered binary-to-one-hot decoder behind a 2-entry skid buffer with valid/ready handshakes.
// Optional range-error output enabled by defining DEC_RANGE_ERR_EN.
module dec_onehot_pipe #(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned NUM_OUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_onehot,
    output logic [SEL_W-1:0]   out_sel
`ifdef DEC_RANGE_ERR_EN
    ,
    output logic               err
`endif
);

    if (SEL_W < 1 || NUM_OUT < 1 || NUM_OUT > (1 << SEL_W)) begin : g_bad_param
        $error("dec_onehot_pipe: need SEL_W >= 1 and 1 <= NUM_OUT <= 2**SEL_W");
    end

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] head_q, head_d;
    logic [SEL_W-1:0] tail_q, tail_d;
    logic             in_xfer;
    logic             out_xfer;

    assign in_ready  = en & (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // head_q always holds the oldest entry; tail_q is only meaningful in StFull.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    head_d  = in_sel;
                    state_d = StOne;
                end
            end
            StOne: begin
                unique case ({in_xfer, out_xfer})
                    2'b10: begin
                        tail_d  = in_sel;
                        state_d = StFull;
                    end
                    2'b01: state_d = StEmpty;
                    2'b11: head_d = in_sel;
                    default: ;
                endcase
            end
            StFull: begin
                if (out_xfer) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Idle outputs are forced to zero so no stale strobe is ever visible.
    always_comb begin
        out_onehot = '0;
        for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (out_valid && (head_q == SEL_W'(i))) begin
                out_onehot[i] = 1'b1;
            end
        end
    end

    assign out_sel = out_valid ? head_q : '0;

`ifdef DEC_RANGE_ERR_EN
    assign err = out_valid && (32'(head_q) >= NUM_OUT);
`endif

endmodule

// File: tb/tb_dec_onehot_pipe.sv
// Directed bench for dec_onehot_pipe: a 2/4 instance for handshake behaviour and a 3/5 instance
// for out-of-range codes.
module tb_dec_onehot_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: SEL_W=2, NUM_OUT=4
    logic       a_en, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0] a_in_sel, a_out_sel;
    logic [3:0] a_out_onehot;
    // Instance B: SEL_W=3, NUM_OUT=5
    logic       b_en, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0] b_in_sel, b_out_sel;
    logic [4:0] b_out_onehot;
`ifdef DEC_RANGE_ERR_EN
    logic       a_err, b_err;
`endif

    dec_onehot_pipe #(.SEL_W(2), .NUM_OUT(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .en        (a_en),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_sel    (a_in_sel),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_onehot(a_out_onehot),
        .out_sel   (a_out_sel)
`ifdef DEC_RANGE_ERR_EN
        ,
        .err       (a_err)
`endif
    );

    dec_onehot_pipe #(.SEL_W(3), .NUM_OUT(5)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .en        (b_en),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_sel    (b_in_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_onehot(b_out_onehot),
        .out_sel   (b_out_sel)
`ifdef DEC_RANGE_ERR_EN
        ,
        .err       (b_err)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] sel;
        logic [3:0] exp_onehot;
    } vec_a_t;

    typedef struct {
        logic [2:0] sel;
        logic [4:0] exp_onehot;
        logic       exp_err;
    } vec_b_t;

    vec_a_t va[4];
    vec_b_t vb[4];
    logic [1:0] seq6[8];
    logic [1:0] prev;

    initial begin
        va[0] = '{2'd0, 4'b0001};
        va[1] = '{2'd1, 4'b0010};
        va[2] = '{2'd2, 4'b0100};
        va[3] = '{2'd3, 4'b1000};
        vb[0] = '{3'd5, 5'b00000, 1'b1};
        vb[1] = '{3'd7, 5'b00000, 1'b1};
        vb[2] = '{3'd4, 5'b10000, 1'b0};
        vb[3] = '{3'd0, 5'b00001, 1'b0};
        seq6 = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd2};

        rst = 1'b1;
        a_en = 1'b1; a_in_valid = 1'b0; a_in_sel = '0; a_out_ready = 1'b1;
        b_en = 1'b1; b_in_valid = 1'b0; b_in_sel = '0; b_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("reset_out_valid", 32'(a_out_valid), 0);
        chk("reset_onehot", 32'(a_out_onehot), 0);
        chk("reset_out_sel", 32'(a_out_sel), 0);
        chk("reset_in_ready", 32'(a_in_ready), 1);
        chk("reset_b_out_valid", 32'(b_out_valid), 0);

        // 1: back-to-back codes, one per cycle, latency 1
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_sel   = va[i].sel;
            #1 chk("t1_in_ready", 32'(a_in_ready), 1);
            @(negedge clk);
            chk("t1_out_valid", 32'(a_out_valid), 1);
            chk("t1_onehot", 32'(a_out_onehot), 32'(va[i].exp_onehot));
            chk("t1_out_sel", 32'(a_out_sel), 32'(va[i].sel));
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("t1_idle_valid", 32'(a_out_valid), 0);
        chk("t1_idle_onehot", 32'(a_out_onehot), 0);

        // 2: backpressure fills the buffer, third code ignored
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_sel = 2'd2;
        @(negedge clk);
        chk("t2_one_onehot", 32'(a_out_onehot), 32'b0100);
        chk("t2_one_in_ready", 32'(a_in_ready), 1);
        a_in_sel = 2'd3;
        @(negedge clk);
        chk("t2_full_in_ready", 32'(a_in_ready), 0);
        chk("t2_full_hold", 32'(a_out_onehot), 32'b0100);
        a_in_sel = 2'd1;
        @(negedge clk);
        chk("t2_ignored_hold", 32'(a_out_onehot), 32'b0100);
        chk("t2_ignored_sel", 32'(a_out_sel), 2);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(negedge clk);
        chk("t2_second_valid", 32'(a_out_valid), 1);
        chk("t2_second_onehot", 32'(a_out_onehot), 32'b1000);
        chk("t2_ready_back", 32'(a_in_ready), 1);
        @(negedge clk);
        chk("t2_drained", 32'(a_out_valid), 0);
        chk("t2_drained_onehot", 32'(a_out_onehot), 0);

        // 3: en low blocks acceptance
        a_en = 1'b0; a_in_valid = 1'b1; a_in_sel = 2'd1;
        #1 chk("t3_in_ready_low", 32'(a_in_ready), 0);
        @(negedge clk);
        chk("t3_no_output", 32'(a_out_valid), 0);
        a_en = 1'b1;
        #1 chk("t3_in_ready_high", 32'(a_in_ready), 1);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("t3_emitted", 32'(a_out_onehot), 32'b0010);
        chk("t3_emitted_valid", 32'(a_out_valid), 1);
        @(negedge clk);
        chk("t3_drained", 32'(a_out_valid), 0);

        // 4: out-of-range codes on the 3/5 instance
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1;
            b_in_sel   = vb[i].sel;
            @(negedge clk);
            chk("t4_out_valid", 32'(b_out_valid), 1);
            chk("t4_onehot", 32'(b_out_onehot), 32'(vb[i].exp_onehot));
            chk("t4_out_sel", 32'(b_out_sel), 32'(vb[i].sel));
`ifdef DEC_RANGE_ERR_EN
            chk("t4_err", 32'(b_err), 32'(vb[i].exp_err));
`endif
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("t4_idle", 32'(b_out_valid), 0);

        // 5: reset while FULL discards held entries
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_sel = 2'd0;
        @(negedge clk);
        a_in_sel = 2'd3;
        @(negedge clk);
        chk("t5_full", 32'(a_in_ready), 0);
        a_in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_valid", 32'(a_out_valid), 0);
        chk("t5_rst_onehot", 32'(a_out_onehot), 0);
        chk("t5_rst_sel", 32'(a_out_sel), 0);
        chk("t5_rst_in_ready", 32'(a_in_ready), 1);
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("t5_nothing_held", 32'(a_out_valid), 0);

        // 6: steady ONE state with simultaneous in/out transfers
        a_in_valid = 1'b1; a_in_sel = 2'd2;
        @(negedge clk);
        prev = 2'd2;
        for (int i = 0; i < 8; i++) begin
            a_in_sel = seq6[i];
            #1 chk("t6_in_ready", 32'(a_in_ready), 1);
            chk("t6_head_before", 32'(a_out_sel), 32'(prev));
            @(negedge clk);
            chk("t6_valid", 32'(a_out_valid), 1);
            chk("t6_onehot", 32'(a_out_onehot), 32'(4'b0001 << seq6[i]));
            prev = seq6[i];
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        chk("t6_drained", 32'(a_out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
